// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Turns an unsigned magnitude result into the signed hi/lo pair for either the mult or the div path.
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             is_mult,
  input  logic             neg_res,
  input  logic             neg_rem,
  input  logic [WIDTH-1:0] mag_hi,
  input  logic [WIDTH-1:0] mag_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    prod_neg = -{mag_hi, mag_lo};
    res_hi   = mag_hi;
    res_lo   = mag_lo;
    if (is_mult) begin
      if (neg_res) {res_hi, res_lo} = prod_neg;
    end else begin
      // Quotient follows the operand sign XOR; remainder follows the dividend.
      if (neg_res) res_lo = -mag_lo;
      if (neg_rem) res_hi = -mag_hi;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit owning HI/LO, with mthi/mtlo writes.
// Optional MULDIV_CANCEL_EN adds a cancel input that aborts an op in CALC/FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MULDIV_CANCEL_EN
  input  logic             cancel,
`endif
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITERS = WIDTH;
  localparam int CW    = $clog2(ITERS);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [2:0]         op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               is_mult;
  logic               in_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     shifted, diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign is_mult = ~op_q[1];

  always_comb begin
    in_signed = ~op[0];
    a_neg     = in_signed & a[WIDTH-1];
    b_neg     = in_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // prod_q holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    add_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{prod_q[0]}} & opb_q};
    mul_next = {add_sum, prod_q[WIDTH-1:1]};
    shifted  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    diff     = shifted - {1'b0, opb_q};
    div_next = diff[WIDTH] ? {shifted[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  end

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_mult (is_mult),
    .neg_res (neg_res_q),
    .neg_rem (neg_rem_q),
    .mag_hi  (prod_q[2*WIDTH-1:WIDTH]),
    .mag_lo  (prod_q[WIDTH-1:0]),
    .res_hi  (fix_hi),
    .res_lo  (fix_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    opb_d     = opb_q;
    dvd_d     = dvd_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              op_d      = op;
              dvd_d     = a;
              opb_d     = a_mag;
              prod_d    = {{WIDTH{1'b0}}, b_mag};
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              cnt_d     = '0;
              state_d   = CALC;
            end
            OP_DIV, OP_DIVU: begin
              op_d      = op;
              dvd_d     = a;
              opb_d     = b_mag;
              prod_d    = {{WIDTH{1'b0}}, a_mag};
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              cnt_d     = '0;
              state_d   = CALC;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      CALC: begin
        prod_d = is_mult ? mul_next : div_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        if (!is_mult && opb_q == '0) begin
          hi_d = dvd_q;
          lo_d = '1;
        end else begin
          hi_d = fix_hi;
          lo_d = fix_lo;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef MULDIV_CANCEL_EN
    if (cancel && (state_q == CALC || state_q == FIX)) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      opb_q     <= '0;
      dvd_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      opb_q     <= opb_d;
      dvd_q     <= dvd_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair.
- Sits beside the single-cycle ALU in the execute stage. Handles mult/multu/div/divu, which the combinational ALU cannot complete in one cycle, plus mthi/mtlo.
- The control unit issues an op with a start/busy/done handshake and stalls the pipeline while busy=1.
- HI/LO are exposed continuously for mfhi/mflo muxing.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH bits each.
- ITERS, WIDTH, shift-add / restoring-divide iteration count; fixed equal to WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  request; accepted only on an edge where busy=0.
- op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 are no-ops.
- a  input  WIDTH  rs operand (multiplicand/dividend; mthi/mtlo source).
- b  input  WIDTH  rt operand (multiplier/divisor).
- busy  output  1  high while an arithmetic op is in flight.
- done  output  1  one-cycle pulse when hi/lo hold a new arithmetic result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: on a rising edge with rst_n=0, go to IDLE with hi=0, lo=0, busy=0, done=0, and clear internal registers. This applies from any state and aborts any op in flight; no partial result reaches hi/lo.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE, start=1, op mult..divu: latch a, b, op. Latch |a| and |b| for signed ops; record the sign of the result (and of the remainder for div). Set iteration counter to 0, busy=1, go to CALC.
- IDLE, start=1, op mthi/mtlo: hi<=a or lo<=a at that edge. busy stays 0, done stays 0, remain in IDLE.
- IDLE, start=1, op 110/111: ignored.
- CALC, multiply: one shift-add step per cycle on a 2*WIDTH product register.
- CALC, divide: one restoring-divide step per cycle, producing quotient and remainder.
- CALC exit: after ITERS cycles (counter 0..ITERS-1), go to FIX.
- FIX:
  - Signed product: negate if result sign is negative.
  - div quotient: negate if signs of a and b differ.
  - div remainder: takes the sign of the dividend.
  - Write hi (product upper / remainder) and lo (product lower / quotient) at the FIX->DONE edge.
- DONE: done=1 and busy=0 for exactly this cycle, then IDLE. A start in the DONE cycle is ignored (accepted from IDLE only).
- Latency: start sampled at edge E0 → busy=1 from E0. hi/lo updated at edge E0+ITERS+1 (E0+33). done=1 in the following cycle.
- start while busy=1 or in DONE: ignored; the in-flight op and its operands are unaffected.
- a/b may change after acceptance without effect.
- Divide by zero (div or divu): hi=a (original dividend), lo=all ones. Same latency and done pulse.
- Signed overflow, div with a=0x80000000 and b=0xFFFFFFFF: lo=0x80000000, hi=0.
- hi/lo hold their value at all times except at the result edge, mthi/mtlo edges, and reset.

Optional Feature:
- Macro: MULDIV_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit).
  - cancel=1 on an edge while in CALC or FIX forces IDLE with busy=0 at that edge.
  - hi/lo are unchanged and done is not pulsed.
  - cancel in IDLE/DONE has no effect.
  - rst_n has priority over cancel.
- Undefined: no cancel port; ops always run to completion.

Decomposition:
- Package muldiv_pkg:
  - WIDTH default constant.
  - 3-bit op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO.
  - state enum: IDLE, CALC, FIX, DONE.
  - Counter width constant: $clog2(ITERS).
- Sub-module muldiv_sign_fix: combinational, takes magnitude result plus sign flags and returns signed-corrected hi/lo. It is shared between the mult and div paths.

Test Plan:
- mult a=0xFFFFFFFD (-3), b=7 → at E0+33 hi=0xFFFFFFFF, lo=0xFFFFFFEB; done=1 only at cycle E0+34; busy high cycles E0..E0+33.
- multu a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=0 → hi=7, lo=0xFFFFFFFF.
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Issue multu 3*5, then start divu 100/7 at cycle E0+10 → second start ignored, hi=0, lo=15. Then mthi a=0x12345678 while idle → hi=0x12345678 next edge, busy stays 0, done stays 0.
- rst_n=0 for one edge at E0+10 of a mult → next cycle busy=0, hi=lo=0, no done pulse. With MULDIV_CANCEL_EN: cancel at E0+5 → busy=0, hi/lo unchanged, no done.
